// File: rtl/mat_result_writer.sv
// Write-back stage of the matrix-multiply datapath: sums every K signed products
// into one result and writes N_OUT results per frame to sequential addresses.
module mat_result_writer #(
  parameter int PROD_W = 32,
  parameter int K      = 8,
  parameter int N_OUT  = 64,
  parameter int ACC_W  = PROD_W + $clog2(K),
  parameter int ADDR_W = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  localparam int TERM_W = (K > 1) ? $clog2(K) : 1;
  localparam int EXT_W  = ACC_W - PROD_W;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [TERM_W-1:0]   term_cnt_q, term_cnt_d;
  logic [ADDR_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic                last_cap_q, last_cap_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ACC_W-1:0]    wr_data_q, wr_data_d;
  logic                done_q, done_d;

  logic                accept_s, capture_s, hs_s;
  logic [ACC_W-1:0]    ext_s, sum_s;

  assign ext_s     = {{EXT_W{in_data[PROD_W-1]}}, in_data};
  assign sum_s     = acc_q + ext_s;
  assign hs_s      = wr_en_q & wr_ready;
  // A stalled write or an already-captured final element blocks the stream.
  assign in_ready  = (state_q == RUN) && !(wr_en_q && !wr_ready) && !last_cap_q;
  assign accept_s  = in_valid & in_ready;
  assign capture_s = accept_s && (term_cnt_q == TERM_W'(K - 1));

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

  // Next-state, accumulation and output-register update logic.
  always_comb begin
    state_d    = state_q;
    term_cnt_d = term_cnt_q;
    elem_cnt_d = elem_cnt_q;
    last_cap_d = last_cap_q;
    acc_d      = acc_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          term_cnt_d = '0;
          elem_cnt_d = '0;
          last_cap_d = 1'b0;
          acc_d      = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (hs_s) begin
          wr_en_d = 1'b0;
        end else begin
          wr_en_d = wr_en_q;
        end
        // A capture overrides the write drop so back-to-back results never bubble.
        if (capture_s) begin
          wr_data_d  = sum_s;
          wr_addr_d  = elem_cnt_q;
          wr_en_d    = 1'b1;
          acc_d      = '0;
          term_cnt_d = '0;
          if (elem_cnt_q == ADDR_W'(N_OUT - 1)) begin
            last_cap_d = 1'b1;
          end else begin
            elem_cnt_d = elem_cnt_q + ADDR_W'(1);
          end
        end else if (accept_s) begin
          acc_d      = sum_s;
          term_cnt_d = term_cnt_q + TERM_W'(1);
        end else begin
          acc_d = acc_q;
        end
        if (hs_s && last_cap_q) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          last_cap_d = 1'b0;
          elem_cnt_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      term_cnt_q <= '0;
      elem_cnt_q <= '0;
      last_cap_q <= 1'b0;
      acc_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_cnt_q <= term_cnt_d;
      elem_cnt_q <= elem_cnt_d;
      last_cap_q <= last_cap_d;
      acc_q      <= acc_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mat_result_writer.sv
// Table-driven frame bench for mat_result_writer: each record describes a frame's
// data pattern, flow-control style and closed-form expected results.
module tb_mat_result_writer;
  localparam int PROD_W = 32;
  localparam int K      = 8;
  localparam int N_OUT  = 64;
  localparam int ACC_W  = 35;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [PROD_W-1:0] in_data = '0;
  logic              wr_ready = 1'b0;
  logic              in_ready, wr_en, busy, done;
  logic [ADDR_W-1:0] wr_addr;
  logic [ACC_W-1:0]  wr_data;

  int checks = 0;
  int errors = 0;

  mat_result_writer #(
    .PROD_W(PROD_W), .K(K), .N_OUT(N_OUT), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // kind: 0 all ones, 1 k-4, 2 0x7FFFFFFF, 3 e-k. Result of element e = base + step*e.
  typedef struct {
    int     kind;
    bit     gaps;
    bit     rdy_rand;
    bit     stall;
    bit     disturb;
    bit     spacing;
    longint exp_base;
    longint exp_step;
  } frame_t;

  frame_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [PROD_W-1:0] prod(input int kind, input int e, input int k);
    case (kind)
      0:       return 32'd1;
      1:       return PROD_W'(k - 4);
      2:       return 32'h7FFF_FFFF;
      default: return PROD_W'(e - k);
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] exp_res(input frame_t f, input int e);
    return ACC_W'(f.exp_base + f.exp_step * longint'(e));
  endfunction

  task automatic run_frame(input frame_t f, input int abort_after);
    int n = 0;
    int writes = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int last_hs = -1;
    int cap_e = 0;
    bit chk_cap = 1'b0;
    bit exp_done = 1'b0;
    bit fin = 1'b0;
    bit kicked = 1'b0;
    if (f.disturb) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h7FFF_FFFF; wr_ready = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = f.disturb && (n >= 100) && !kicked;
      if (start) kicked = 1'b1;
      if (f.stall) wr_ready = !(writes == 0 && stall_cnt < 5);
      else if (f.rdy_rand) wr_ready = ($urandom % 4) != 0;
      else wr_ready = 1'b1;
      in_valid = (n < N_OUT * K) && (f.gaps ? (($urandom % 2) == 1) : 1'b1);
      in_data = in_valid ? prod(f.kind, n / K, n % K) : '0;
      #1;
      if (exp_done) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_in_ready", in_ready, 0);
        fin = 1'b1;
      end else begin
        chk("done_early", done, 0);
      end
      if (chk_cap) begin
        chk("cap_wr_en", wr_en, 1);
        chk("cap_data", wr_data, exp_res(f, cap_e));
        chk_cap = 1'b0;
      end
      if (wr_en && !wr_ready) begin
        stall_cnt++;
        chk("stall_in_ready", in_ready, 0);
        if (f.stall) begin
          chk("stall_addr", wr_addr, 0);
          chk("stall_data", wr_data, exp_res(f, 0));
        end
      end
      if (wr_en && wr_ready) begin
        chk("wr_addr", wr_addr, writes);
        chk("wr_data", wr_data, exp_res(f, writes));
        if (f.spacing && last_hs >= 0) chk("spacing", cyc - last_hs, K);
        last_hs = cyc;
        writes++;
        if (writes == N_OUT) exp_done = 1'b1;
      end
      if (in_valid && in_ready) begin
        if (n % K == K - 1) begin
          chk_cap = 1'b1;
          cap_e = n / K;
        end
        n++;
        if (abort_after > 0 && n == abort_after) fin = 1'b1;
      end
      if (cyc > 6000) begin
        checks++;
        errors++;
        $display("FAIL timeout actual=%0d writes required=%0d", writes, N_OUT);
        fin = 1'b1;
      end
    end
    if (abort_after == 0) begin
      if (f.stall) chk("stall_cycles", stall_cnt, 5);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("done_one_cycle", done, 0);
      chk("write_count", writes, N_OUT);
    end
  endtask

  initial begin
    frame_t f_abort;
    tbl[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'sd8, 64'sd0};
    tbl[1] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -64'sd4, 64'sd0};
    tbl[2] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'sh3_FFFF_FFF8, 64'sd0};
    tbl[3] = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'sd8, 64'sd0};
    tbl[4] = '{3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -64'sd28, 64'sd8};
    tbl[5] = '{3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -64'sd28, 64'sd8};
    f_abort = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -64'sd28, 64'sd8};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(tbl[i], 0);

    // Reset lands in the middle of a frame after 100 accepted products.
    run_frame(f_abort, 100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    run_frame(tbl[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mat_result_writer.md
# mat_result_writer

Write-back end of the matrix-multiply datapath. Accepts the stream of signed partial products from the multiplier, which is fed by the operand address generator. Accumulates every K consecutive products into one dot-product result and writes each result to the result memory at a sequential address. One frame is N_OUT results. A one-cycle `done` pulse marks the end of each frame.

## Interface
- `PROD_W`, 32: width of each signed incoming product.
- `K`, 8: products per dot product (the inner dimension).
- `N_OUT`, 64: results per frame (8x8 output).
- `ACC_W`, PROD_W+$clog2(K): accumulator and result width.
- `ADDR_W`, $clog2(N_OUT): result memory address width.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset: asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a frame; ignored unless state is IDLE.
- `in_valid`  in  1  product valid.
- `in_data`  in  PROD_W  signed product.
- `in_ready`  out  1  block can accept a product this cycle.
- `wr_en`  out  1  result write request.
- `wr_addr`  out  ADDR_W  result address, 0..N_OUT-1.
- `wr_data`  out  ACC_W  signed result.
- `wr_ready`  in  1  result memory accepts the write.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse when the frame's last write completes.

## Operation
- States:
  - IDLE: on `start`, go to RUN.
  - RUN: after the handshake of write N_OUT-1, go to IDLE and pulse `done`.
- Registers:
  - `term_cnt`: 0..K-1.
  - `elem_cnt`: 0..N_OUT-1.
  - `acc`: ACC_W bits.
  - Output register holding `wr_en`/`wr_addr`/`wr_data`.
- Entering RUN clears `term_cnt`, `elem_cnt` and `acc`.
- Accept = `in_valid && in_ready`.
- `in_ready` = (state==RUN) && !(`wr_en` && !`wr_ready`) && !(last element already captured).
- Accept with `term_cnt` < K-1: `acc` <= `acc` + sext(`in_data`), then `term_cnt`++.
- Accept with `term_cnt` == K-1:
  - `wr_data` <= `acc` + sext(`in_data`).
  - `wr_addr` <= `elem_cnt`.
  - `wr_en` <= 1.
  - `acc` <= 0, `term_cnt` <= 0, `elem_cnt`++ (saturating at N_OUT-1 when it is the last element).
- Write handshake = `wr_en && wr_ready`.
  - `wr_en` drops the next cycle unless a new result is captured in that same cycle.
  - A capture in the same cycle as a handshake is legal; it reloads the output register back-to-back.
- `wr_en` high with `wr_ready` low: `wr_addr` and `wr_data` are held stable and `in_ready` = 0 (no stream loss).
- Arithmetic is two's complement wrap at ACC_W. ACC_W covers K full-scale products, so no overflow occurs at the defaults.
- `in_valid` in IDLE is ignored; nothing is accumulated.
- `start` during RUN is ignored.
- Reset mid-frame:
  - All state cleared immediately and asynchronously.
  - Any pending write is dropped.
  - No `done` pulse.

## Timing
- Reset values: state IDLE, `in_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `busy` 0, `done` 0; all counters and `acc` 0.
- `start` at cycle t: `busy` and `in_ready` are high at t+1.
- Latency: K-th accept at cycle t gives `wr_en` = 1 at t+1 with the final sum.
- Sustained throughput with `wr_ready` held 1 is one product per cycle with no bubbles.
- `done` is high in the cycle after the final write handshake, together with `busy` = 0 and `in_ready` = 0.
- A new `start` is accepted in that same cycle or any later cycle.
- `done` lasts exactly one cycle.

## Test plan
- Reset, then `start`; stream 512 products all = 1 with `wr_ready` = 1.
  - 64 writes, each `wr_data` = 8, `wr_addr` 0..63 in order, consecutive results 8 cycles apart.
  - `done` one cycle after write 63.
- Element e, term k driven with `in_data` = k-4 (k=0..7).
  - Every `wr_data` = -4: signed sign-extension check.
  - Then all products = 0x7FFFFFFF: `wr_data` = 0x3_FFFFFFF8 (35-bit), no wrap.
- `wr_ready` held 0 for 5 cycles at the first write.
  - `wr_en`/`wr_addr` 0/`wr_data` stable all 5 cycles, `in_ready` = 0, no product lost.
  - Final results identical to the unstalled run.
- Random `in_valid` gaps (about 50%) combined with random `wr_ready`.
  - Result sequence matches a reference model; exactly 64 writes and 1 `done`.
- Assert `rst` = 0 after 100 accepts.
  - All outputs 0 the same cycle.
  - A new `start` then yields `wr_addr` from 0 and correct sums.
- `start` pulsed mid-frame and `in_valid` pulsed in IDLE.
  - No effect: addresses continue in sequence, `acc` is not disturbed.
